// File: rtl/playback_ctrl_pkg.sv
// Shared audio-path definitions: default widths, sequencer states and speed codes.
package playback_ctrl_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_FETCH  = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  typedef enum logic [1:0] {
    SPD_NORM = 2'b00,
    SPD_FAST = 2'b01,
    SPD_SLOW = 2'b10
  } speed_e;

  // The unused code 11 plays at normal speed.
  function automatic speed_e norm_speed(input logic [1:0] code);
    return (code == 2'b11) ? SPD_NORM : speed_e'(code);
  endfunction

endpackage

// File: rtl/lrc_edge_det.sv
// Registers the codec frame clock and flags the first cycle of its high half.
module lrc_edge_det
  import playback_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_lrc,
  output logic o_event
);

  logic r_lrc;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lrc <= 1'b0;
    end else begin
      r_lrc <= i_lrc;
    end
  end

  assign o_event = i_lrc & ~r_lrc;

endmodule

// File: rtl/playback_ctrl.sv
// Playback sequencer: one SRAM sample fetch per codec frame, with pause/stop
// and normal, double (skip) and half (repeat) speed.
module playback_ctrl
  import playback_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              i_bclk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrc,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_oe_n,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_play,
  output logic              o_done
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_rep;
  logic              r_pause_pend;
  logic [2:0]        r_lat_cnt;
  logic              r_done;
  speed_e            r_spd;
  speed_e            r_spd_prev;

  logic              w_event;
  speed_e            w_spd;
  logic [ADDR_W:0]   w_step;
  logic [ADDR_W:0]   w_next;
  logic              w_past_end;
  logic              w_last_beat;

  lrc_edge_det u_lrc_edge_det (
    .i_clk   (i_bclk),
    .i_reset (i_reset),
    .i_lrc   (i_daclrc),
    .o_event (w_event)
  );

  assign w_spd       = norm_speed(i_speed);
  assign w_step      = (r_spd == SPD_FAST) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  // One extra bit so stepping past the top of the address space still reads as past the end.
  assign w_next      = {1'b0, r_addr} + w_step;
  assign w_past_end  = w_next > {1'b0, i_end_addr};
  assign w_last_beat = (r_lat_cnt == LAT_LAST);

  always_ff @(posedge i_bclk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_rep        <= 1'b0;
      r_pause_pend <= 1'b0;
      r_lat_cnt    <= '0;
      r_done       <= 1'b0;
      r_spd        <= SPD_NORM;
      r_spd_prev   <= SPD_NORM;
    end else begin
      r_done     <= 1'b0;
      r_spd_prev <= w_spd;
      if (i_stop) begin
        r_state      <= ST_IDLE;
        r_addr       <= '0;
        r_data       <= '0;
        r_rep        <= 1'b0;
        r_pause_pend <= 1'b0;
        r_lat_cnt    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_addr       <= '0;
            r_data       <= '0;
            r_rep        <= 1'b0;
            r_pause_pend <= 1'b0;
            if (i_start) r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (i_pause) begin
              r_state <= ST_PAUSED;
            end else if (w_event) begin
              if (w_spd == SPD_SLOW && r_rep) begin
                r_rep <= 1'b0;
              end else begin
                r_state   <= ST_FETCH;
                r_lat_cnt <= '0;
                r_spd     <= w_spd;
              end
            end
          end
          ST_FETCH: begin
            if (i_pause) r_pause_pend <= 1'b1;
            if (w_last_beat) begin
              r_data       <= i_sram_rdata;
              r_pause_pend <= 1'b0;
              if (w_past_end) begin
                r_state <= ST_IDLE;
                r_addr  <= '0;
                r_done  <= 1'b1;
              end else begin
                r_addr  <= w_next[ADDR_W-1:0];
                r_rep   <= (r_spd == SPD_SLOW);
                r_state <= (r_pause_pend || i_pause) ? ST_PAUSED : ST_WAIT;
              end
            end else begin
              r_lat_cnt <= r_lat_cnt + 3'd1;
            end
          end
          ST_PAUSED: begin
            if (!i_pause && i_start) r_state <= ST_WAIT;
          end
          default: r_state <= ST_IDLE;
        endcase
        // A speed change discards any half-speed repeat still owed.
        if (w_spd != r_spd_prev) r_rep <= 1'b0;
      end
    end
  end

  assign o_play      = (r_state == ST_WAIT) || (r_state == ST_FETCH);
  assign o_sram_oe_n = (r_state != ST_FETCH);
  assign o_sram_addr = r_addr;
  assign o_dac_data  = r_data;
  assign o_done      = r_done;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl with a READ_LAT=3 SRAM model returning address+100.
module tb_playback_ctrl;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic [17:0] end_addr = '0;
  logic        daclrc = 1'b0;
  logic [15:0] sram_rdata = 16'hDEAD;
  logic [17:0] sram_addr;
  logic        oe_n;
  logic [15:0] dac;
  logic        play;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int oe_cnt  = 0;
  int ev_age  = 255;
  int done_cnt = 0;
  logic lrc_prev = 1'b0;
  logic rec_en = 1'b0;
  logic [17:0] reads[$];
  logic [15:0] dacs[$];

  playback_ctrl #(.ADDR_W(18), .DATA_W(16), .READ_LAT(RL)) dut (
    .i_bclk       (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_pause      (pause),
    .i_stop       (stop),
    .i_speed      (speed),
    .i_end_addr   (end_addr),
    .i_daclrc     (daclrc),
    .i_sram_rdata (sram_rdata),
    .o_sram_addr  (sram_addr),
    .o_sram_oe_n  (oe_n),
    .o_dac_data   (dac),
    .o_play       (play),
    .o_done       (done)
  );

  initial forever #5 clk = ~clk;

  // 32 bclk per frame: 16 high, 16 low.
  initial forever begin
    repeat (16) @(posedge clk);
    #1 daclrc = ~daclrc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // SRAM model and bus monitor, evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    if (oe_n) oe_cnt = 0; else oe_cnt = oe_cnt + 1;
    sram_rdata = (!oe_n && oe_cnt >= RL) ? (sram_addr[15:0] + 16'd100) : 16'hDEAD;
    if (!oe_n && oe_cnt == 1) reads.push_back(sram_addr);
    if (daclrc && !lrc_prev) ev_age = 0; else if (ev_age < 255) ev_age = ev_age + 1;
    lrc_prev = daclrc;
    if (!oe_n) check_eq("no_frame_in_fetch", {31'b0, ev_age == 0}, 0);
    if (ev_age == RL + 1 && rec_en && (play || done)) dacs.push_back(dac);
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; tick(1); pause = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic clear_logs();
    reads.delete(); dacs.delete(); done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && !done; i++) tick(1);
    check_eq(tag, {31'b0, done}, 1);
  endtask

  function automatic int rd(input int i);
    return (i < reads.size()) ? int'(reads[i]) : -1;
  endfunction

  function automatic int dd(input int i);
    return (i < dacs.size()) ? int'(dacs[i]) : -1;
  endfunction

  task automatic run_to_done(input string tag, input logic [1:0] spd, input logic [17:0] ea);
    speed = spd; end_addr = ea; clear_logs(); rec_en = 1'b1;
    pulse_start();
    check_eq({tag, "_play_on"}, {31'b0, play}, 1);
    wait_done({tag, "_done"}, 600);
    tick(1);
    check_eq({tag, "_done_once"}, done_cnt, 1);
    check_eq({tag, "_play_off"}, {31'b0, play}, 0);
    check_eq({tag, "_addr0"}, {14'b0, sram_addr}, 0);
    check_eq({tag, "_dac_clr"}, {16'b0, dac}, 0);
  endtask

  initial begin
    int i;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    tick(3);
    check_eq("rst_play", {31'b0, play}, 0);
    check_eq("rst_oe_n", {31'b0, oe_n}, 1);
    check_eq("rst_addr", {14'b0, sram_addr}, 0);
    check_eq("rst_dac", {16'b0, dac}, 0);
    check_eq("rst_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    tick(2);

    run_to_done("norm", 2'b00, 18'd3);
    check_eq("norm_nreads", reads.size(), 4);
    for (int k = 0; k < 4; k++) check_eq("norm_dac", dd(k), 100 + k);
    for (int k = 0; k < 4; k++) check_eq("norm_addr", rd(k), k);
    $display("[TB] normal end=3: %0d reads, %0d samples", reads.size(), dacs.size());

    run_to_done("fast", 2'b01, 18'd6);
    check_eq("fast_nreads", reads.size(), 4);
    for (int k = 0; k < 4; k++) check_eq("fast_addr", rd(k), 2 * k);
    for (int k = 0; k < 4; k++) check_eq("fast_dac", dd(k), 100 + 2 * k);
    $display("[TB] 2x end=6: %0d reads", reads.size());

    run_to_done("fast_odd", 2'b01, 18'd5);
    check_eq("fast_odd_nreads", reads.size(), 3);
    check_eq("fast_odd_last", rd(2), 4);
    $display("[TB] 2x end=5: %0d reads", reads.size());

    run_to_done("slow", 2'b10, 18'd1);
    check_eq("slow_nreads", reads.size(), 2);
    check_eq("slow_dac0", dd(0), 100);
    check_eq("slow_dac1", dd(1), 100);
    check_eq("slow_dac2", dd(2), 101);
    $display("[TB] 1/2x end=1: %0d reads, %0d samples", reads.size(), dacs.size());

    run_to_done("one", 2'b00, 18'd0);
    check_eq("one_nreads", reads.size(), 1);
    check_eq("one_dac", dd(0), 100);
    $display("[TB] end=0: %0d reads", reads.size());

    // Pause during the fetch of address 2, hold five frames, resume.
    speed = 2'b00; end_addr = 18'd5; clear_logs();
    pulse_start();
    for (i = 0; i < 400 && !(reads.size() == 3 && !oe_n); i++) tick(1);
    check_eq("pause_reach_fetch2", rd(2), 2);
    pulse_pause();
    tick(5);
    check_eq("pause_play", {31'b0, play}, 0);
    check_eq("pause_dac", {16'b0, dac}, 102);
    check_eq("pause_addr", {14'b0, sram_addr}, 3);
    tick(160);
    check_eq("pause_nreads", reads.size(), 3);
    check_eq("pause_oe_n", {31'b0, oe_n}, 1);
    check_eq("pause_dac_held", {16'b0, dac}, 102);
    pulse_start();
    check_eq("resume_play", {31'b0, play}, 1);
    for (i = 0; i < 100 && reads.size() < 4; i++) tick(1);
    check_eq("resume_addr", rd(3), 3);
    $display("[TB] pause/resume: next read addr %0d", rd(3));
    pulse_stop();
    tick(2);

    // Stop and start together mid-playback.
    speed = 2'b00; end_addr = 18'd10; clear_logs();
    pulse_start();
    for (i = 0; i < 200 && dacs.size() < 2; i++) tick(1);
    check_eq("ss_progress", dacs.size(), 2);
    stop = 1'b1; start = 1'b1; tick(1); stop = 1'b0; start = 1'b0;
    check_eq("ss_play", {31'b0, play}, 0);
    check_eq("ss_addr", {14'b0, sram_addr}, 0);
    check_eq("ss_dac", {16'b0, dac}, 0);
    check_eq("ss_oe_n", {31'b0, oe_n}, 1);
    check_eq("ss_no_done", done_cnt, 0);
    clear_logs();
    pulse_start();
    for (i = 0; i < 100 && reads.size() < 1; i++) tick(1);
    check_eq("ss_refetch0", rd(0), 0);
    $display("[TB] stop+start: refetch addr %0d", rd(0));
    pulse_stop();
    tick(2);

    // Reset during the first beat of a three-cycle fetch.
    speed = 2'b00; end_addr = 18'd10; clear_logs();
    pulse_start();
    for (i = 0; i < 100 && !(!oe_n && oe_cnt == 1); i++) tick(1);
    check_eq("rm_in_fetch", {31'b0, oe_n}, 0);
    rst_n = 1'b0;
    tick(1);
    check_eq("rm_play", {31'b0, play}, 0);
    check_eq("rm_oe_n", {31'b0, oe_n}, 1);
    check_eq("rm_addr", {14'b0, sram_addr}, 0);
    check_eq("rm_dac", {16'b0, dac}, 0);
    check_eq("rm_done", {31'b0, done}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check_eq("rm_no_done", done_cnt, 0);
    check_eq("rm_dac_after", {16'b0, dac}, 0);
    $display("[TB] reset mid-fetch: dac=%0d done_cnt=%0d", dac, done_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/playback_ctrl.md
# playback_ctrl

Playback sequencer for the audio datapath. It runs in the `bclk` domain and walks SRAM sample addresses from 0 to `end_addr`. Once per `daclrc` frame it fetches one 16-bit sample and presents it to the DAC serializer on `dac_data`, gating the serializer with `play`. It supports start, pause/resume and stop, plus normal, double-speed (sample skip) and half-speed (sample repeat) playback.

## Interface
- `ADDR_W`, 18, SRAM sample address width.
- `DATA_W`, 16, sample width; samples are signed two's complement.
- `READ_LAT`, 1, cycles from `sram_oe_n` low to valid `sram_rdata`; legal range 1..4.

Ports:
- `bclk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts playback from IDLE or resumes from PAUSED.
- `pause`  in  1  one-cycle pulse; pauses playback.
- `stop`  in  1  one-cycle pulse; aborts playback and rewinds to address 0.
- `speed`  in  2  playback speed:
  - 00 = normal.
  - 01 = 2x.
  - 10 = 1/2x.
  - 11 = treated as 00.
- `end_addr`  in  ADDR_W  last valid sample address, inclusive; sampled on every compare.
- `daclrc`  in  1  codec frame clock, synchronous to `bclk`.
- `sram_rdata`  in  DATA_W  SRAM read data.
- `sram_addr`  out  ADDR_W  SRAM read address.
- `sram_oe_n`  out  1  SRAM output enable, active-low.
- `dac_data`  out  DATA_W  sample presented to the DAC serializer.
- `play`  out  1  serializer enable.
- `done`  out  1  one-cycle pulse when the last sample has been fetched.

## Operation
- States: IDLE, WAIT (playing, awaiting frame), FETCH, PAUSED.
- Frame event: `daclrc` is registered each cycle. An event occurs when `daclrc`=1 and the registered value is 0, i.e. at the start of the high half.
- IDLE:
  - Outputs: `play`=0, `sram_addr`=0, `sram_oe_n`=1, `dac_data`=0.
  - `start` → WAIT.
- WAIT:
  - `play`=1.
  - On a frame event: if speed is 1/2x and the repeat flag is set, clear the flag and stay in WAIT with `dac_data` unchanged.
  - Otherwise go to FETCH.
- FETCH:
  - `sram_oe_n`=0 for exactly READ_LAT cycles.
  - On the last of those cycles, capture `sram_rdata` into `dac_data` and advance `sram_addr`.
  - Advance is +2 at 2x and +1 otherwise. At 1/2x, also set the repeat flag.
  - The next address is computed in ADDR_W+1 bits. If it exceeds `end_addr`: pulse `done`, go to IDLE, set `sram_addr`=0. `dac_data` holds for the current frame and clears on IDLE entry +1 cycle.
  - If the next address does not exceed `end_addr`, go to WAIT (or PAUSED if a pause is pending).
- PAUSED:
  - Outputs: `play`=0, `sram_oe_n`=1; `sram_addr`, `dac_data` and the repeat flag are held.
  - `start` → WAIT.
- Command priority when pulses coincide: `stop` > `pause` > `start`.
  - `stop` in any state: next cycle is IDLE with all outputs at their reset values. An in-flight fetch is abandoned.
  - `pause` in FETCH: latch a pending pause, complete the fetch, then enter PAUSED.
  - `pause` in IDLE: ignored.
  - `start` in WAIT or FETCH: ignored.
- `speed` change: takes effect at the next frame event. Any change clears the repeat flag.
- `end_addr`=0: plays exactly one sample, then `done`.
- 2x with odd `end_addr` gap: the last fetched address is the largest even offset ≤ `end_addr`.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE; `play`=0, `sram_oe_n`=1, `sram_addr`=0, `dac_data`=0, `done`=0; repeat flag, pending pause and `daclrc` register cleared.
- A frame event is detected in cycle N. `sram_oe_n` is low in cycles N+1..N+READ_LAT, and `dac_data` is valid from cycle N+READ_LAT+1.
  - This is well inside the 16-cycle high half, so `dac_data` is stable before `daclrc` falls.
- `play` rises the cycle after `start` is accepted and falls the cycle after `stop`, `pause` (from WAIT) or completion.
- `done` is high exactly one cycle, coincident with IDLE entry.
- Throughput: one fetch per frame event maximum. Frame events arriving during FETCH are impossible for legal `daclrc`; the bench asserts this.

## Structure
- Shared audio package holds the `ADDR_W`/`DATA_W` defaults, the state enum (IDLE, WAIT, FETCH, PAUSED) and the speed codes (SPD_NORM, SPD_FAST, SPD_SLOW).
- One sub-module, `lrc_edge_det`: registers `daclrc` and emits a one-cycle frame-event pulse; it is reset by `reset`.
- The address advance and end compare stay inline in `playback_ctrl`.

## Test plan
- **Normal, end:** reset, `end_addr`=3, `start`, drive `daclrc` at 32 bclk/frame, SRAM returns address+100.
  - `dac_data` = 100, 101, 102, 103 on four consecutive frames.
  - `done` pulses once; `play`=0 and `sram_addr`=0 afterwards.
- **2x:** `speed`=01, `end_addr`=6.
  - Fetched addresses are 0, 2, 4, 6; `done` after 4 fetches.
- **1/2x:** `speed`=10, `end_addr`=1.
  - `dac_data` sequence is 100, 100, 101, 101; exactly 2 SRAM reads.
- **Pause/resume:** pause during the FETCH of address 2, hold 5 frames, then `start`.
  - Address 2 completes; `play`=0 and no reads while paused.
  - Resume fetches address 3 next.
- **Simultaneous/stop:** `stop` and `start` in the same cycle mid-playback → IDLE, `sram_addr`=0, `dac_data`=0.
  - `start` alone afterwards refetches address 0.
- **Reset mid-fetch:** `reset`=0 while `sram_oe_n`=0 with READ_LAT=3.
  - Next cycle, all outputs are at their reset values.
  - No `done` pulse and no `dac_data` update from the abandoned read.
